// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port data memory bus.
// The arbiter uses the slave modport; the requesters/memory side uses master.
interface dmem_arbiter_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         req0;
  logic         we0;
  logic [A-1:0] addr0;
  logic [W-1:0] wdata0;
  logic         lock0;
  logic         gnt0;
  logic         rvalid0;
  logic [W-1:0] rdata0;

  logic         req1;
  logic         we1;
  logic [A-1:0] addr1;
  logic [W-1:0] wdata1;
  logic         lock1;
  logic         gnt1;
  logic         rvalid1;
  logic [W-1:0] rdata1;

  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-cycle data memory: core (port 0) has priority,
// the DMA port (port 1) gets a starvation guard and bounded locked bursts.
module dmem_arbiter #(
  parameter int W          = 8,
  parameter int A          = 8,
  parameter int STARVE_LIM = 4,
  parameter int LOCK_MAX   = 8
) (
  input logic            clk,
  input logic            Reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [7:0] LOCK_MAX_C   = 8'(LOCK_MAX);
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

  owner_t       lock_owner_reg;
  logic [7:0]   lock_cnt_reg;
  logic [3:0]   starve_cnt_reg;
  logic [1:0]   rvalid_reg;
  logic [W-1:0] rdata_reg [2];

  logic       lock_full;
  logic       hold0, hold1;
  logic       excl0, excl1;
  logic       starved;
  logic [1:0] win;
  logic [1:0] we_v;
  logic [7:0] lock_cnt_inc;

  assign we_v = {bus.we1, bus.we0};

  always_comb begin
    lock_full = (lock_cnt_reg >= LOCK_MAX_C);
    hold0     = (lock_owner_reg == OWN_P0) && bus.req0 && !lock_full;
    hold1     = (lock_owner_reg == OWN_P1) && bus.req1 && !lock_full;
    // An owner that used up its burst sits out one cycle, but only if the other port wants in.
    excl0     = (lock_owner_reg == OWN_P0) && lock_full && bus.req1;
    excl1     = (lock_owner_reg == OWN_P1) && lock_full && bus.req0;
    starved   = (starve_cnt_reg >= STARVE_LIM_C);
    win       = 2'b00;
    if (hold0)
      win[0] = 1'b1;
    else if (hold1)
      win[1] = 1'b1;
    else if (bus.req1 && !excl1 && starved)
      win[1] = 1'b1;
    else if (bus.req0 && !excl0)
      win[0] = 1'b1;
    else if (bus.req1 && !excl1)
      win[1] = 1'b1;
  end

  assign lock_cnt_inc = lock_full ? lock_cnt_reg : lock_cnt_reg + 8'd1;

  // Grants and memory drive are gated so nothing reaches the memory while Reset is low.
  assign bus.gnt0      = win[0] & Reset;
  assign bus.gnt1      = win[1] & Reset;
  assign bus.mem_we    = Reset & ((win[0] & bus.we0) | (win[1] & bus.we1));
  assign bus.mem_addr  = !Reset ? '0 : (win[1] ? bus.addr1  : bus.addr0);
  assign bus.mem_wdata = !Reset ? '0 : (win[1] ? bus.wdata1 : bus.wdata0);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      starve_cnt_reg <= 4'd0;
      lock_owner_reg <= OWN_NONE;
      lock_cnt_reg   <= 8'd0;
    end else begin
      if (bus.req1 && !win[1])
        starve_cnt_reg <= (starve_cnt_reg == 4'hF) ? starve_cnt_reg : starve_cnt_reg + 4'd1;
      else
        starve_cnt_reg <= 4'd0;

      if (win[0] && bus.lock0) begin
        lock_owner_reg <= OWN_P0;
        lock_cnt_reg   <= (lock_owner_reg == OWN_P0) ? lock_cnt_inc : 8'd1;
      end else if (win[1] && bus.lock1) begin
        lock_owner_reg <= OWN_P1;
        lock_cnt_reg   <= (lock_owner_reg == OWN_P1) ? lock_cnt_inc : 8'd1;
      end else begin
        lock_owner_reg <= OWN_NONE;
        lock_cnt_reg   <= 8'd0;
      end
    end
  end

  // Read return: one-cycle latency, data held until the port's next granted read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= '0;
      end else begin
        rvalid_reg[gi] <= win[gi] && !we_v[gi];
        if (win[gi] && !we_v[gi])
          rdata_reg[gi] <= bus.mem_rdata;
      end
    end
  end

  assign bus.rvalid0 = rvalid_reg[0];
  assign bus.rvalid1 = rvalid_reg[1];
  assign bus.rdata0  = rdata_reg[0];
  assign bus.rdata1  = rdata_reg[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Inputs change on the falling edge; outputs are sampled 1 ns later or on the next falling edge.
module tb_dmem_arbiter;
  localparam int W = 8;
  localparam int A = 8;

  logic clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_arbiter_if #(.W(W), .A(A)) bus ();

  dmem_arbiter #(.W(W), .A(A), .STARVE_LIM(4), .LOCK_MAX(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else
      $display("ok   %s = %0h (t=%0t)", tag, obs, $time);
  endtask

  task automatic drive0(input logic r, input logic w, input logic [A-1:0] a,
                        input logic [W-1:0] d, input logic l);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [A-1:0] a,
                        input logic [W-1:0] d, input logic l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] p1;
    logic       p0_done;

    // Reset state: outputs forced low even with a live request.
    Reset = 1'b0;
    drive0(1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
    drive1(1'b1, 1'b1, 8'h77, 8'h88, 1'b1);
    #1;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Preload memory[0x10] = A5 through port 0.
    drive0(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0);
    #1 check("pre_gnt0", bus.gnt0, 1);
    check("pre_mem_we", bus.mem_we, 1);
    @(negedge clk);
    check("pre_rvalid0", bus.rvalid0, 0);

    // Test 1: port-0 read.
    drive0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    #1 check("t1_gnt0", bus.gnt0, 1);
    check("t1_gnt1", bus.gnt1, 0);
    check("t1_mem_we", bus.mem_we, 0);
    @(negedge clk);
    check("t1_rvalid0", bus.rvalid0, 1);
    check("t1_rdata0", bus.rdata0, 8'hA5);

    // Test 4: write then read; rdata0 holds across the write.
    drive0(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0);
    #1 check("t4_wr_gnt0", bus.gnt0, 1);
    @(negedge clk);
    check("t4_wr_rvalid0", bus.rvalid0, 0);
    check("t4_rdata0_hold", bus.rdata0, 8'hA5);
    check("t4_mem20", mem[8'h20], 8'h3C);
    drive0(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    #1 check("t4_rd_gnt0", bus.gnt0, 1);
    @(negedge clk);
    check("t4_rd_rvalid0", bus.rvalid0, 1);
    check("t4_rd_rdata0", bus.rdata0, 8'h3C);
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Test 2: contention for 6 cycles, starvation grant in cycle 4.
    drive0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    drive1(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("t2_c%0d_gnt0", c), bus.gnt0, (c != 4));
      check($sformatf("t2_c%0d_gnt1", c), bus.gnt1, (c == 4));
      @(negedge clk);
      if (c == 4) begin
        check("t2_rvalid1", bus.rvalid1, 1);
        check("t2_rdata1", bus.rdata1, 8'h3C);
        check("t2_starve_clr", dut.starve_cnt_reg, 0);
      end
    end
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Test 3: locked port-1 write burst to 0..9, port 0 writes 0x40 from cycle 2.
    p1 = 8'd0;
    p0_done = 1'b0;
    for (int c = 0; c < 11; c++) begin
      drive1(1'b1, 1'b1, p1, 8'(8'h80 + p1), 1'b1);
      drive0((c >= 2) && !p0_done, 1'b1, 8'h40, 8'h77, 1'b0);
      #1;
      check($sformatf("t3_c%0d_gnt1", c), bus.gnt1, (c != 8));
      check($sformatf("t3_c%0d_gnt0", c), bus.gnt0, (c == 8));
      if (c == 8) p0_done = 1'b1;
      else        p1 = p1 + 8'd1;
      @(negedge clk);
      if (c == 7) check("t3_no_p0_midburst", (mem[8'h40] == 8'h77), 0);
    end
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      p1 = 8'(i);
      check($sformatf("t3_mem%0d", i), mem[p1], 8'(8'h80 + i));
    end
    check("t3_mem40", mem[8'h40], 8'h77);

    // Test 5: reset while port 1 holds the lock with lock_cnt = 3.
    for (int c = 0; c < 3; c++) begin
      drive1(1'b1, 1'b0, 8'(c), 8'h00, 1'b1);
      #1 check($sformatf("t5_c%0d_gnt1", c), bus.gnt1, 1);
      @(negedge clk);
    end
    check("t5_lock_cnt", dut.lock_cnt_reg, 3);
    check("t5_rvalid1_pre", bus.rvalid1, 1);
    check("t5_rdata1_pre", bus.rdata1, 8'h82);
    Reset = 1'b0;
    #1;
    check("t5_rst_gnt1", bus.gnt1, 0);
    check("t5_rst_mem_we", bus.mem_we, 0);
    check("t5_rst_rvalid1", bus.rvalid1, 0);
    check("t5_rst_rdata1", bus.rdata1, 0);
    @(negedge clk);
    Reset = 1'b1;
    drive0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    #1;
    check("t5_after_gnt0", bus.gnt0, 1);
    check("t5_after_gnt1", bus.gnt1, 0);
    @(negedge clk);
    drive0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);

    // Test 6: idle bus for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("t6_c%0d_mem_we", c), bus.mem_we, 0);
      @(negedge clk);
      check($sformatf("t6_c%0d_rvalid0", c), bus.rvalid0, 0);
      check($sformatf("t6_c%0d_rvalid1", c), bus.rvalid1, 0);
    end
    check("t6_mem10", mem[8'h10], 8'hA5);
    check("t6_mem20", mem[8'h20], 8'h3C);
    check("t6_mem03", mem[8'h03], 8'h83);
    check("t6_mem40", mem[8'h40], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
